// File: rtl/avalon_block_reader_pkg.sv
// Shared types and constants for the Avalon-MM block reader.
package avalon_block_reader_pkg;

  localparam int unsigned ADDR_W_DEF       = 16;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned LEN_W_DEF        = 17;
  localparam int unsigned READ_LATENCY_DEF = 1;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;

  localparam logic [DATA_W_DEF/8-1:0] BYTEENABLE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Count must represent 0..depth inclusive.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/avalon_block_reader_sync_fifo.sv
// First-word-fall-through FIFO with synchronous active-high reset and occupancy count.
module sync_fifo_fwft #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only honoured when a pop frees the slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/avalon_block_reader.sv
// Avalon-MM read master streaming a contiguous word block out through a valid/ready port.
// Optional running checksum output enabled by AVALON_BLOCK_READER_CHECKSUM_EN.
module avalon_block_reader
  import avalon_block_reader_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned LEN_W        = LEN_W_DEF,
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop
`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam int unsigned CNT_W = fifo_cnt_w(FIFO_DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        iss_left_q, iss_left_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        out_idx_q, out_idx_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    issue_c;
  logic                    credit_ok;
  logic                    st_fire;
  logic                    fifo_push;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;

  // Every in-flight read already owns a FIFO slot, so returned data can never overflow.
  assign credit_ok = (32'($countones(pipe_q)) + 32'(fifo_count)) < FIFO_DEPTH;
  assign fifo_push = pipe_q[READ_LATENCY-1];
  assign st_fire   = st_valid && st_ready;

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_read       = issue_c;
  assign avm_chipselect = issue_c;
  assign avm_byteenable = '1;
  assign st_valid       = !fifo_empty;
  assign st_sop         = st_valid && (out_idx_q == '0);
  assign st_eop         = st_valid && (out_idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_left_d = iss_left_q;
    len_d      = len_q;
    out_idx_d  = out_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue_c    = 1'b0;
    pipe_d     = READ_LATENCY'({pipe_q, 1'b0});
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d     = start_addr;
            iss_left_d = length;
            len_d      = length;
            out_idx_d  = '0;
            busy_d     = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue_c    = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          iss_left_d = iss_left_q - LEN_W'(1);
          if (iss_left_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (st_fire && st_eop) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pipe_d = READ_LATENCY'({pipe_q, issue_c});
    if (st_fire) out_idx_d = out_idx_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      iss_left_q <= '0;
      len_q      <= '0;
      out_idx_q  <= '0;
      pipe_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_left_q <= iss_left_d;
      len_q      <= len_d;
      out_idx_q  <= out_idx_d;
      pipe_q     <= pipe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (avm_readdata),
    .pop_i   (st_fire),
    .data_o  (st_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full && !st_fire));
  end

`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
  logic [31:0] csum_q;

  // Holds its value after done until the next start clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start) begin
      csum_q <= '0;
    end else if (st_fire) begin
      csum_q <= csum_q + 32'(st_data);
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_avalon_block_reader.sv
// Scoreboard bench for avalon_block_reader: memory-slave model, stream checker, bus checker.
module tb_avalon_block_reader;
  import avalon_block_reader_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] start_addr;
  logic [16:0] length;
  logic        busy;
  logic        done;
  logic [15:0] avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;
`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_iss    = 0;
  int   n_pop    = 0;
  int   done_cnt = 0;
  int   cs_cnt   = 0;
  bit   cs_mode  = 0;
  exp_t sb_q[$];
  logic [15:0] addr_exp_q[$];
  exp_t        mon_e;
  logic [15:0] mon_a;

  avalon_block_reader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_read       (avm_read),
    .avm_byteenable (avm_byteenable),
    .avm_readdata   (avm_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop)
`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (cs_mode) begin
      case (a)
        16'd0:   return 32'hFFFF_FFFF;
        16'd1:   return 32'h0000_0002;
        16'd2:   return 32'h0000_0005;
        default: return 32'h0;
      endcase
    end
    return 32'hA000 + 32'(a);
  endfunction

  // Fixed one-cycle-latency memory slave.
  always @(posedge clk) begin
    if (avm_read && avm_chipselect) avm_readdata <= mem_word(avm_address);
  end

  // Bus and stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      n_iss = n_pop;
    end else begin
      if (avm_chipselect) cs_cnt++;
      if (done) done_cnt++;
      if (addr_exp_q.size() == 0) begin
        check("rd_extra", 32'(avm_read), 32'd0);
      end else if (avm_read) begin
        mon_a = addr_exp_q.pop_front();
        check("rd_addr", 32'(avm_address), 32'(mon_a));
        check("credit", 32'((n_iss - n_pop) < 4), 32'd1);
        n_iss++;
      end
      if (st_valid && st_ready) begin
        if (sb_q.size() == 0) begin
          check("st_extra", 32'(st_valid), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("st_data", st_data, mon_e.data);
          check("st_sop", 32'(st_sop), 32'(mon_e.sop));
          check("st_eop", 32'(st_eop), 32'(mon_e.eop));
        end
        n_pop++;
      end
    end
  end

  task automatic push_block(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      addr_exp_q.push_back(a + 16'(i));
      sb_q.push_back('{data: mem_word(a + 16'(i)), sop: (i == 0), eop: (i == n - 1)});
    end
  endtask

  task automatic run_block(input logic [15:0] a, input int n, input int lo, input int hi,
                           input int restart);
    int cyc;
    int d0;
    bit seen;
    push_block(a, n);
    start_addr = a;
    length     = 17'(n);
    start      = 1'b1;
    st_ready   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0    = done_cnt;
    seen  = 0;
    cyc   = 1;
    while (!seen && cyc < 500) begin
      if (cyc == 1) check("busy_set", 32'(busy), 32'd1);
      st_ready = !(cyc >= lo && cyc <= hi);
      if (cyc == restart) begin
        start      = 1'b1;
        start_addr = 16'h5000;
        length     = 17'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        check("busy_at_done", 32'(busy), 32'd0);
      end
      cyc++;
    end
    start    = 1'b0;
    st_ready = 1'b1;
    check("done_seen", 32'(seen), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("addr_empty", 32'(addr_exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_read"}, 32'(avm_read), 32'd0);
    check({pfx, "_cs"}, 32'(avm_chipselect), 32'd0);
    check({pfx, "_addr"}, 32'(avm_address), 32'd0);
    check({pfx, "_valid"}, 32'(st_valid), 32'd0);
    check({pfx, "_sop"}, 32'(st_sop), 32'd0);
    check({pfx, "_eop"}, 32'(st_eop), 32'd0);
  endtask

  initial begin
    int c0;
    int d0;
    int p0;
    int cyc;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    st_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("byteen", 32'(avm_byteenable), 32'(BYTEENABLE_ALL));
    reset = 1'b0;
    @(posedge clk); #1;

    run_block(16'h0010, 4, 0, -1, 0);
    run_block(16'h0100, 16, 3, 12, 0);
    run_block(16'hFFFE, 4, 0, -1, 0);

    // Zero length: done next cycle, no bus activity.
    c0         = cs_cnt;
    start_addr = 16'h0300;
    length     = 17'd0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zl_done", 32'(done), 32'd1);
    check("zl_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("zl_done_pulse", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("zl_no_cs", 32'(cs_cnt - c0), 32'd0);

    // Start while busy must be ignored.
    run_block(16'h0200, 5, 0, -1, 2);

    // Reset after three of eight words.
    push_block(16'h0020, 8);
    p0         = n_pop;
    start_addr = 16'h0020;
    length     = 17'd8;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while ((n_pop - p0) < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_three_words", 32'(n_pop - p0), 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid");
    reset = 1'b0;
    sb_q.delete();
    addr_exp_q.delete();
    d0 = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);
    run_block(16'h0000, 2, 0, -1, 0);

`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
    cs_mode = 1;
    run_block(16'h0000, 3, 0, -1, 0);
    check("checksum", checksum, 32'h0000_0006);
    cs_mode = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
